// File: rtl/exec_pkg.sv
// Shared definitions for the execute-to-memory flag stage: condition and ALU-op encodings,
// default widths, and the condition evaluation helper.
package exec_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int RD_W_DEFAULT   = 3;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_C      = 2'b10,
    COND_NEVER  = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    NAND = 2'b01,
    OFF  = 2'b10
  } alu_op_e;

  // Conditions are always judged against the architectural (registered) flags.
  function automatic logic cond_pass(input cond_e c, input logic zero_f, input logic carry_f);
    logic ok;
    ok = 1'b0;
    unique case (c)
      COND_ALWAYS: ok = 1'b1;
      COND_Z:      ok = zero_f;
      COND_C:      ok = carry_f;
      COND_NEVER:  ok = 1'b0;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exec_flag_stage_if.sv
// Valid/ready bus between the ALU, the flag stage and the memory stage.
// master = the side that drives instructions and out_ready, slave = the flag stage.
interface exec_flag_stage_if #(
  parameter int DATA_W = exec_pkg::DATA_W_DEFAULT,
  parameter int RD_W   = exec_pkg::RD_W_DEFAULT
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_zero;
  logic [1:0]        cond;
  logic              carry_we;
  logic              zero_we;
  logic              rf_we;
  logic [RD_W-1:0]   rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_rf_we;

  modport master (
    output in_valid, alu_out, alu_carry, alu_zero, cond, carry_we, zero_we, rf_we, rd,
           flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_rf_we
  );

  modport slave (
    input  in_valid, alu_out, alu_carry, alu_zero, cond, carry_we, zero_we, rf_we, rd,
           flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_rf_we
  );
endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF; clr_n is a synchronous active-low clear.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n)
      count <= '0;
    else if (en && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/exec_flag_stage.sv
// Execute-to-memory pipeline register with carry/zero flags and conditional squash.
// Optional performance counters are built when EXEC_PERF_CNT_EN is defined.
module exec_flag_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_W   = RD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  exec_flag_stage_if.slave    bus,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic [15:0]         exec_cnt,
  output logic [15:0]         squash_cnt
);

  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [RD_W-1:0]   rd_q;
  logic              rf_we_q;
  logic              accept;
  logic              cond_ok;

  // The slot frees up in the same cycle it drains, giving full throughput.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign cond_ok      = cond_pass(cond_e'(bus.cond), zero_flag, carry_flag);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      rf_we_q    <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      rf_we_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      if (cond_ok) begin
        result_q <= bus.alu_out;
        rd_q     <= bus.rd;
        rf_we_q  <= bus.rf_we;
        if (bus.carry_we) carry_flag <= bus.alu_carry;
        if (bus.zero_we)  zero_flag  <= bus.alu_zero;
      end else begin
        // Failed condition: keep the slot as a bubble that cannot write back.
        rf_we_q <= 1'b0;
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_rf_we  = rf_we_q;

`ifdef EXEC_PERF_CNT_EN
  sat_counter16 u_exec_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (accept && cond_ok),
    .count (exec_cnt)
  );

  sat_counter16 u_squash_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (accept && !cond_ok),
    .count (squash_cnt)
  );
`else
  assign exec_cnt   = 16'h0000;
  assign squash_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_exec_flag_stage.sv
// Directed bench for exec_flag_stage; counter expectations follow EXEC_PERF_CNT_EN.
module tb_exec_flag_stage;

`ifdef EXEC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] exec_cnt;
  logic [15:0] squash_cnt;
  int          total;
  int          bad;

  exec_flag_stage_if bus ();

  exec_flag_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cnt_exp(input int n);
    return PERF ? 16'(n) : 16'h0000;
  endfunction

  task automatic set_instr(input logic v, input logic [1:0] c, input logic [15:0] res,
                           input logic cy, input logic z, input logic cwe, input logic zwe,
                           input logic rwe, input logic [2:0] d);
    bus.in_valid  = v;
    bus.cond      = c;
    bus.alu_out   = res;
    bus.alu_carry = cy;
    bus.alu_zero  = z;
    bus.carry_we  = cwe;
    bus.zero_we   = zwe;
    bus.rf_we     = rwe;
    bus.rd        = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    total++;
    if ({bus.out_valid, bus.out_rf_we, carry_flag, zero_flag} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_bits got=%b want=0000",
               {bus.out_valid, bus.out_rf_we, carry_flag, zero_flag});
    end
    total++;
    if (bus.out_result !== 16'h0000 || bus.out_rd !== 3'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%0d want=0000/0", bus.out_result, bus.out_rd);
    end
    total++;
    if (exec_cnt !== 16'h0000 || squash_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL reset_cnt got=%h/%h want=0000/0000", exec_cnt, squash_cnt);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_exec_add();
    @(negedge clk);
    set_instr(1'b1, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0000 || bus.out_rd !== 3'd3) begin
      bad++;
      $display("FAIL add_out got=%b/%h/%0d want=1/0000/3", bus.out_valid, bus.out_result, bus.out_rd);
    end
    total++;
    if (carry_flag !== 1'b1 || zero_flag !== 1'b1 || bus.out_rf_we !== 1'b1) begin
      bad++;
      $display("FAIL add_flags got=c%b z%b we%b want=c1 z1 we1", carry_flag, zero_flag, bus.out_rf_we);
    end
    total++;
    if (exec_cnt !== cnt_exp(1)) begin
      bad++;
      $display("FAIL add_exec_cnt got=%h want=%h", exec_cnt, cnt_exp(1));
    end
    @(negedge clk);
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_squash();
    // Clear carry first (zero stays 1).
    @(negedge clk);
    set_instr(1'b1, 2'b00, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    step();
    total++;
    if (carry_flag !== 1'b0 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL clr_carry got=c%b z%b want=c0 z1", carry_flag, zero_flag);
    end
    @(negedge clk);
    set_instr(1'b1, 2'b10, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_rf_we !== 1'b0 || carry_flag !== 1'b0) begin
      bad++;
      $display("FAIL squash got=v%b we%b c%b want=v1 we0 c0", bus.out_valid, bus.out_rf_we, carry_flag);
    end
    total++;
    if (squash_cnt !== cnt_exp(1) || exec_cnt !== cnt_exp(2)) begin
      bad++;
      $display("FAIL squash_cnt got=%h/%h want=%h/%h", squash_cnt, exec_cnt, cnt_exp(1), cnt_exp(2));
    end
    @(negedge clk);
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_instr(1'b1, 2'b00, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    step();
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_instr(1'b1, 2'b00, 16'h5A5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_in_ready got=%b want=0", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hA5A5 || bus.out_rd !== 3'd5 ||
          carry_flag !== 1'b0 || zero_flag !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=v%b %h rd%0d c%b z%b want=v1 a5a5 rd5 c0 z1",
                 i, bus.out_valid, bus.out_result, bus.out_rd, carry_flag, zero_flag);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h5A5A || bus.out_rd !== 3'd6 ||
        carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      bad++;
      $display("FAIL release_accept got=v%b %h rd%0d c%b z%b want=v1 5a5a rd6 c1 z0",
               bus.out_valid, bus.out_result, bus.out_rd, carry_flag, zero_flag);
    end
    total++;
    if (exec_cnt !== cnt_exp(4)) begin
      bad++;
      $display("FAIL stall_exec_cnt got=%h want=%h", exec_cnt, cnt_exp(4));
    end
    @(negedge clk);
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_instr(1'b1, 2'b00, 16'h0C0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    step();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    set_instr(1'b1, 2'b00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_rf_we !== 1'b0) begin
      bad++;
      $display("FAIL flush_out got=v%b we%b want=v0 we0", bus.out_valid, bus.out_rf_we);
    end
    total++;
    if (zero_flag !== 1'b0 || carry_flag !== 1'b1 || exec_cnt !== cnt_exp(5)) begin
      bad++;
      $display("FAIL flush_flags got=z%b c%b cnt%h want=z0 c1 cnt%h",
               zero_flag, carry_flag, exec_cnt, cnt_exp(5));
    end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_instr(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    step();
    total++;
    if (zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL b2b_zero got=%b want=1", zero_flag);
    end
    @(negedge clk);
    set_instr(1'b1, 2'b01, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h00FF || bus.out_rf_we !== 1'b1 ||
        bus.out_rd !== 3'd2) begin
      bad++;
      $display("FAIL b2b_exec got=v%b %h we%b rd%0d want=v1 00ff we1 rd2",
               bus.out_valid, bus.out_result, bus.out_rf_we, bus.out_rd);
    end
    total++;
    if (exec_cnt !== cnt_exp(7) || squash_cnt !== cnt_exp(1)) begin
      bad++;
      $display("FAIL b2b_cnt got=%h/%h want=%h/%h", exec_cnt, squash_cnt, cnt_exp(7), cnt_exp(1));
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_instr(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_hold got=%b want=1", bus.out_valid);
    end
    @(negedge clk);
    reset_n = 1'b0;
    step();
    total++;
    if ({bus.out_valid, bus.out_rf_we, carry_flag, zero_flag} !== 4'b0000 ||
        bus.out_result !== 16'h0000 || bus.out_rd !== 3'd0) begin
      bad++;
      $display("FAIL midstall_reset got=v%b we%b c%b z%b %h rd%0d want=all zero",
               bus.out_valid, bus.out_rf_we, carry_flag, zero_flag, bus.out_result, bus.out_rd);
    end
    total++;
    if (exec_cnt !== 16'h0000 || squash_cnt !== 16'h0000 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midstall_reset_cnt got=%h/%h rdy%b want=0000/0000 rdy1",
               exec_cnt, squash_cnt, bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_exec_add();
    test_squash();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
